// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
// The count-width helper sizes the credit counters from module parameters.
package rv_fetch_pkg;

    localparam int PC_STEP = 4;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous prefetch FIFO with clear; head is read combinationally so a
// pushed entry is visible the cycle after the push and push+pop may coincide.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !srst_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: credit-limited valid/ready imem requests,
// in-order responses into a prefetch FIFO, and redirect flush with discard.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int                   ADDR_WIDTH      = 32,
    parameter int                   INST_WIDTH      = 32,
    parameter int                   FIFO_DEPTH      = 4,
    parameter int                   MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_next_pc
);
    localparam int OCW = cnt_width(MAX_OUTSTANDING);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW  = ((OCW > FCW) ? OCW : FCW) + 1;
    localparam int EW  = ADDR_WIDTH + INST_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [OCW-1:0]        outst_q, outst_d;
    logic [OCW-1:0]        discard_q, discard_d;
    logic [FCW-1:0]        fifo_count;
    logic [SW-1:0]         credit_used;
    logic                  fifo_empty, fifo_full;
    logic                  req_fire, rsp_accept, push, pop;
    logic [EW-1:0]         head;

    assign redirect_base = redirect_pc & ~ADDR_WIDTH'(3);

    // Slots already promised: buffered entries plus responses that will be kept.
    assign credit_used = SW'(fifo_count) + SW'(outst_q) - SW'(discard_q);

    assign imem_req_valid = !rst && !redirect_valid
                         && (outst_q < OCW'(MAX_OUTSTANDING))
                         && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && (outst_q != '0);
    assign push       = rsp_accept && (discard_q == '0) && !redirect_valid;

    assign inst_valid   = !fifo_empty && !redirect_valid && !rst;
    assign pop          = inst_valid && inst_ready;
    assign inst_pc      = head[EW-1:INST_WIDTH];
    assign inst_data    = inst_valid ? head[INST_WIDTH-1:0] : INST_WIDTH'(RV_NOP);
    assign inst_next_pc = inst_pc + ADDR_WIDTH'(PC_STEP);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + OCW'(req_fire) - OCW'(rsp_accept);
        discard_d  = discard_q - OCW'(rsp_accept && (discard_q != '0));
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            discard_d  = outst_q - OCW'(rsp_accept);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
            if (push)     rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst_i  (rst),
        .clr_i   (redirect_valid),
        .push_i  (push),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outst_q == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomized bench for rv_fetch_unit against a queue-level model of the
// fetch stream, with a few literal pins for reset, redirect and wrap behaviour.
module tb_rv_fetch_unit;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_next_pc;

    always #5 clk = ~clk;

    rv_fetch_unit #(
        .ADDR_WIDTH      (32),
        .INST_WIDTH      (32),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_next_pc   (inst_next_pc)
    );

    typedef struct { logic [31:0] pc; bit doomed; } infl_t;
    typedef struct { logic [31:0] addr; int due; } memrsp_t;

    infl_t       infl[$];
    logic [31:0] fifo_m[$];
    memrsp_t     mem_q[$];
    logic [31:0] exp_fetch = RPC;
    int          last_due = 0;
    int          it = 0;
    int          total = 0;
    int          bad = 0;

    bit          watch = 0;
    int          mark_iter = 0;
    int          seen_iter = -1;
    logic [31:0] seen_pc = '0;
    bit          obs_req = 0;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_npc[$];
    logic [31:0] pop_data[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic int n_kept();
        int n = 0;
        foreach (infl[i]) if (!infl[i].doomed) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s iter=%0d got=%h want=%h", name, it, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit redir, input logic [31:0] tgt,
                        input bit irdy, input bit qrdy, input int lat);
        bit      ereq, einst, rspv;
        int      due;
        infl_t   e;
        memrsp_t m;
        @(negedge clk);
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = tgt;
        inst_ready     = irdy;
        imem_req_ready = qrdy;
        rspv           = 1'b0;
        if (!r && mem_q.size() > 0 && mem_q[0].due <= it) begin
            rspv          = 1'b1;
            imem_rsp_data = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_rsp_valid = rspv;
        #1;
        ereq  = !r && !redir && infl.size() < MAXO && (fifo_m.size() + n_kept()) < DEPTH;
        einst = !r && !redir && fifo_m.size() > 0;
        obs_req = imem_req_valid;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ereq});
        if (ereq) chk("req_addr", imem_req_addr, exp_fetch);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, einst});
        if (einst) begin
            chk("inst_pc", inst_pc, fifo_m[0]);
            chk("inst_data", inst_data, mem_word(fifo_m[0]));
            chk("inst_next_pc", inst_next_pc, fifo_m[0] + 32'd4);
        end
        if (r || redir) begin
            watch     = 1;
            mark_iter = it;
        end else if (watch && inst_valid) begin
            watch     = 0;
            seen_iter = it;
            seen_pc   = inst_pc;
        end
        if (!r && !redir && inst_valid && irdy) begin
            $display("pop iter=%0d pc=%h data=%h", it, inst_pc, inst_data);
            pop_pc.push_back(inst_pc);
            pop_npc.push_back(inst_next_pc);
            pop_data.push_back(inst_data);
        end
        if (r) begin
            infl.delete();
            fifo_m.delete();
            mem_q.delete();
            exp_fetch = RPC;
            last_due  = it;
        end else begin
            if (einst && irdy) void'(fifo_m.pop_front());
            if (rspv && infl.size() > 0) begin
                e = infl.pop_front();
                if (!e.doomed && !redir) fifo_m.push_back(e.pc);
            end
            if (redir) begin
                fifo_m.delete();
                foreach (infl[i]) infl[i].doomed = 1;
                exp_fetch = tgt & ~32'd3;
            end
            if (ereq && qrdy) begin
                e.pc     = exp_fetch;
                e.doomed = 0;
                infl.push_back(e);
                due = (it + lat > last_due + 1) ? it + lat : last_due + 1;
                last_due = due;
                m.addr = exp_fetch;
                m.due  = due;
                mem_q.push_back(m);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        it++;
    endtask

    initial begin
        // Reset release and streaming across the address wrap.
        step(1, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);
        chk("rst_first_valid_iter", seen_iter, 4);
        chk("rst_first_pc", seen_pc, 32'hFFFF_FFF8);
        chk("wrap_pc0", pop_pc[0], 32'hFFFF_FFF8);
        chk("wrap_data0", pop_data[0], 32'h5A5A_5A5D);
        chk("wrap_pc1", pop_pc[1], 32'hFFFF_FFFC);
        chk("wrap_npc1", pop_npc[1], 32'h0000_0000);
        chk("wrap_pc2", pop_pc[2], 32'h0000_0000);

        // Redirect with a response and a pop in the same cycle; low bits ignored.
        step(0, 1, 32'h0000_0203, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);
        chk("redir_latency", seen_iter, 15);
        chk("redir_pc", seen_pc, 32'h0000_0200);

        // Consumer stall: credit runs out and issue stops.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1);
        chk("stall_no_issue", {31'b0, obs_req}, 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);

        // Memory back-pressure, then a redirect with two slow requests in flight.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 3);
        step(0, 1, 32'h0000_0200, 1, 1, 3);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 3);
        chk("slow_redir_pc", seen_pc, 32'h0000_0200);

        // Mid-stream reset with requests outstanding.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 2);
        step(1, 0, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);
        chk("rerst_latency", seen_iter - mark_iter, 3);
        chk("rerst_pc", seen_pc, 32'hFFFF_FFF8);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
